phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module : phase_sequencer
// Brief  : One-hot instruction timing-phase generator with a stretchable
//          wait phase, stall freeze, halt / single-step control and
//          active-cycle / completed-instruction counters.
// Rev    : 1.0  initial release
// ============================================================================
module phase_sequencer #(
   parameter int NUM_PHASES = 5,
   parameter int WAIT_PHASE = 3,
   parameter int WAIT_W     = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  Run,
   input  logic                  Halt,
   input  logic                  StepMode,
   input  logic                  Step,
   input  logic                  Stall,
   input  logic [WAIT_W-1:0]     WaitStates,
   output logic [NUM_PHASES-1:0] T,
   output logic                  InstrStart,
   output logic                  InstrDone,
   output logic                  Halted,
   output logic                  Busy,
   output logic [CNT_W-1:0]      CycleCount,
   output logic [CNT_W-1:0]      InstrCount
);

   localparam int                   c_pw        = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
   localparam logic [c_pw-1:0]      c_last_ph   = c_pw'(NUM_PHASES - 1);
   localparam logic [c_pw-1:0]      c_wait_ph   = c_pw'(WAIT_PHASE);
   localparam logic [c_pw-1:0]      c_ph_one    = c_pw'(1);
   localparam logic [NUM_PHASES-1:0] c_t_one    = {{(NUM_PHASES-1){1'b0}}, 1'b1};
   localparam logic [WAIT_W-1:0]    c_wait_one  = WAIT_W'(1);
   localparam logic [CNT_W-1:0]     c_cnt_one   = CNT_W'(1);
   localparam logic [CNT_W-1:0]     c_cnt_max   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_WAIT   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t                  r_state;
   logic [c_pw-1:0]         r_phase;
   logic [WAIT_W-1:0]       r_wait_cnt;
   logic [NUM_PHASES-1:0]   r_t;
   logic                    r_start;
   logic                    r_halted;
   logic                    r_busy;
   logic [CNT_W-1:0]        r_cycle_cnt;
   logic [CNT_W-1:0]        r_instr_cnt;

   state_t                  w_state_nxt;
   logic [c_pw-1:0]         w_phase_nxt;
   logic [WAIT_W-1:0]       w_wait_nxt;
   logic [NUM_PHASES-1:0]   w_t_nxt;
   logic                    w_load;
   logic [c_pw-1:0]         w_load_ph;
   logic                    w_begin;
   logic                    w_done;

   // Instruction completes on the last phase in RUN; a stall defers it.
   assign w_done = (r_state == ST_RUN) && (r_phase == c_last_ph) && !Stall;

   // Next-state, next-phase and wait-counter decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_wait_nxt  = r_wait_cnt;
      w_load      = 1'b0;
      w_load_ph   = '0;
      w_begin     = 1'b0;
      w_t_nxt     = '0;

      case (r_state)
         ST_IDLE: begin
            if (Run) begin
               w_load  = 1'b1;
               w_begin = 1'b1;
            end
         end
         ST_RUN: begin
            if (!Stall) begin
               if (r_phase == c_last_ph) begin
                  // Boundary: halt/step take priority over a plain stop.
                  if (Halt || StepMode) begin
                     w_state_nxt = ST_HALTED;
                  end else if (!Run) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_load  = 1'b1;
                     w_begin = 1'b1;
                  end
               end else begin
                  w_load    = 1'b1;
                  w_load_ph = r_phase + c_ph_one;
               end
            end
         end
         ST_WAIT: begin
            // The last extra cycle is spent back in RUN so the normal
            // advance / completion logic applies to it.
            if (!Stall) begin
               if (r_wait_cnt <= c_wait_one) begin
                  w_state_nxt = ST_RUN;
                  w_wait_nxt  = '0;
               end else begin
                  w_wait_nxt  = r_wait_cnt - c_wait_one;
               end
            end
         end
         ST_HALTED: begin
            if (Step) begin
               w_load  = 1'b1;
               w_begin = 1'b1;
            end else if (!Halt && !StepMode) begin
               if (Run) begin
                  w_load  = 1'b1;
                  w_begin = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Entering a phase: the wait phase samples WaitStates exactly once here.
      if (w_load) begin
         w_phase_nxt = w_load_ph;
         if ((w_load_ph == c_wait_ph) && (WaitStates != '0)) begin
            w_state_nxt = ST_WAIT;
            w_wait_nxt  = WaitStates;
         end else begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
         end
      end

      if ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_WAIT)) begin
         w_t_nxt = c_t_one << w_phase_nxt;
      end
   end

   // State, phase strobes, status flags and counters.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_phase     <= '0;
         r_wait_cnt  <= '0;
         r_t         <= '0;
         r_start     <= 1'b0;
         r_halted    <= 1'b0;
         r_busy      <= 1'b0;
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_t        <= w_t_nxt;
         r_start    <= w_begin;
         r_halted   <= (w_state_nxt == ST_HALTED);
         r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_WAIT);
         if (r_busy && (r_cycle_cnt != c_cnt_max)) begin
            r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
         end
         if (w_done) begin
            r_instr_cnt <= r_instr_cnt + c_cnt_one;
         end
      end
   end

   assign T          = r_t;
   assign InstrStart = r_start;
   assign InstrDone  = w_done;
   assign Halted     = r_halted;
   assign Busy       = r_busy;
   assign CycleCount = r_cycle_cnt;
   assign InstrCount = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_phase_sequencer
// Brief  : Directed self-checking bench for phase_sequencer; per-instruction
//          expectations are queued by the stimulus and retired by a monitor
//          on every InstrDone.
// Rev    : 1.0  initial release
// ============================================================================
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        Reset;
   logic        Run, Halt, StepMode, Step, Stall;
   logic [3:0]  WaitStates;
   logic [4:0]  T;
   logic        InstrStart, InstrDone, Halted, Busy;
   logic [15:0] CycleCount, InstrCount;

   logic        run4;
   logic        zero4 = 1'b0;
   logic [3:0]  ws4 = 4'd0;
   logic [4:0]  t4;
   logic        start4, done4, halted4, busy4;
   logic [3:0]  ccount4, icount4;

   typedef struct {
      int len;
      int icount;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   int exp_b[7] = '{1, 2, 4, 8, 8, 8, 16};
   int exp_c[8] = '{1, 2, 2, 2, 4, 8, 16, 16};
   int exp_d[11] = '{1, 2, 4, 8, 16, 0, 1, 2, 4, 8, 16};

   phase_sequencer dut (
      .clk(clk), .Reset(Reset), .Run(Run), .Halt(Halt), .StepMode(StepMode),
      .Step(Step), .Stall(Stall), .WaitStates(WaitStates), .T(T),
      .InstrStart(InstrStart), .InstrDone(InstrDone), .Halted(Halted),
      .Busy(Busy), .CycleCount(CycleCount), .InstrCount(InstrCount)
   );

   phase_sequencer #(.CNT_W(4)) dut4 (
      .clk(clk), .Reset(Reset), .Run(run4), .Halt(zero4), .StepMode(zero4),
      .Step(zero4), .Stall(zero4), .WaitStates(ws4), .T(t4),
      .InstrStart(start4), .InstrDone(done4), .Halted(halted4),
      .Busy(busy4), .CycleCount(ccount4), .InstrCount(icount4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int l, input int c);
      exp_t e;
      e.len    = l;
      e.icount = c;
      q.push_back(e);
   endtask

   // Monitor: measure each instruction from InstrStart and retire one
   // queued expectation per InstrDone.
   int mon_len    = 0;
   bit mon_active = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!Reset) begin
         chk("t_onehot", int'($countones(T) <= 1), 1);
         if (InstrStart) begin
            mon_len    = 1;
            mon_active = 1'b1;
         end else if (mon_active) begin
            mon_len++;
         end
         if (InstrDone) begin
            if (q.size() == 0) begin
               chk("done_with_empty_queue", q.size(), 1);
            end else begin
               e = q.pop_front();
               chk("instr_len", mon_len, e.len);
               chk("instr_count_at_done", int'(InstrCount), e.icount);
            end
            mon_active = 1'b0;
         end
      end
   end

   initial begin
      Reset = 1'b1; Run = 1'b0; Halt = 1'b0; StepMode = 1'b0;
      Step = 1'b0; Stall = 1'b0; WaitStates = 4'd0; run4 = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_t", T, 0);
      chk("rst_start", InstrStart, 0);
      chk("rst_done", InstrDone, 0);
      chk("rst_halted", Halted, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_ccount", CycleCount, 0);
      chk("rst_icount", InstrCount, 0);
      tick(); Reset = 1'b0;
      tick();

      // Free-running, no wait states.
      push_exp(5, 0); push_exp(5, 1);
      Run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 9) Run = 1'b0;
         @(negedge clk);
         chk("A_t", T, 1 << (i % 5));
      end
      tick(); @(negedge clk);
      chk("A_idle_t", T, 0);
      chk("A_busy", Busy, 0);
      chk("A_icount", InstrCount, 2);
      chk("A_ccount", CycleCount, 10);

      // Two wait states; a later WaitStates change must be ignored.
      push_exp(7, 2);
      WaitStates = 4'd2; Run = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i == 3) WaitStates = 4'd7;
         if (i == 6) Run = 1'b0;
         @(negedge clk);
         chk("B_t", T, exp_b[i]);
         if (i == 4) chk("B_busy_in_wait", Busy, 1);
      end
      tick(); WaitStates = 4'd0; @(negedge clk);
      chk("B_icount", InstrCount, 3);
      chk("B_ccount", CycleCount, 17);

      // Stall two cycles in T[1], one cycle in the last phase.
      push_exp(8, 3);
      Run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 1) Stall = 1'b1;
         if (i == 3) Stall = 1'b0;
         if (i == 6) Stall = 1'b1;
         if (i == 7) begin Stall = 1'b0; Run = 1'b0; end
         @(negedge clk);
         chk("C_t", T, exp_c[i]);
         chk("C_start", InstrStart, (i == 0) ? 1 : 0);
         if (i == 6) chk("C_done_stalled", InstrDone, 0);
         if (i == 7) chk("C_done", InstrDone, 1);
      end
      tick(); @(negedge clk);
      chk("C_icount", InstrCount, 4);
      chk("C_ccount", CycleCount, 25);

      // Halt mid-instruction, then resume with Run.
      push_exp(5, 4); push_exp(5, 5);
      Run = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (i == 2) Halt = 1'b1;
         if (i == 5) Halt = 1'b0;
         if (i == 10) Run = 1'b0;
         @(negedge clk);
         chk("D_t", T, exp_d[i]);
         if (i == 5) begin
            chk("D_halted", Halted, 1);
            chk("D_busy", Busy, 0);
         end
      end
      tick(); @(negedge clk);
      chk("D_icount", InstrCount, 6);
      chk("D_ccount", CycleCount, 35);
      chk("D_not_halted", Halted, 0);

      // Step outside HALTED is ignored; then single-step three instructions.
      tick(); Step = 1'b1;
      tick(); Step = 1'b0;
      @(negedge clk);
      chk("E_step_ignored_t", T, 0);
      chk("E_step_ignored_busy", Busy, 0);
      push_exp(5, 6);
      StepMode = 1'b1; Run = 1'b1;
      tick(); Run = 1'b0;
      @(negedge clk);
      chk("E_first_t", T, 1);
      for (int k = 0; k < 3; k++) begin
         repeat (10) tick();
         @(negedge clk);
         chk("E_halted", Halted, 1);
         chk("E_halted_t", T, 0);
         push_exp(5, 7 + k);
         tick(); Step = 1'b1;
         tick(); Step = 1'b0;
         @(negedge clk);
         chk("E_step_t", T, 1);
         chk("E_step_start", InstrStart, 1);
      end
      repeat (10) tick();
      @(negedge clk);
      chk("E_icount", InstrCount, 10);
      chk("E_halted_end", Halted, 1);
      chk("E_ccount", CycleCount, 55);
      tick(); StepMode = 1'b0;
      tick(); @(negedge clk);
      chk("E_idle_halted", Halted, 0);
      chk("E_idle_busy", Busy, 0);

      // Asynchronous reset in T[3]; restart afterwards.
      Run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(); @(negedge clk);
         chk("F_t", T, 1 << i);
      end
      #1 Reset = 1'b1;
      #1;
      chk("F_rst_t", T, 0);
      chk("F_rst_start", InstrStart, 0);
      chk("F_rst_done", InstrDone, 0);
      chk("F_rst_halted", Halted, 0);
      chk("F_rst_busy", Busy, 0);
      chk("F_rst_ccount", CycleCount, 0);
      chk("F_rst_icount", InstrCount, 0);
      #1 Reset = 1'b0;
      push_exp(5, 0);
      tick(); Run = 1'b0;
      @(negedge clk);
      chk("F_restart_t", T, 1);
      chk("F_restart_start", InstrStart, 1);
      repeat (5) tick();
      @(negedge clk);
      chk("F_icount", InstrCount, 1);
      chk("F_ccount", CycleCount, 5);
      chk("F_busy", Busy, 0);

      // Narrow counters: 20 instructions wrap InstrCount, CycleCount saturates.
      tick(); run4 = 1'b1;
      repeat (100) tick();
      run4 = 1'b0;
      tick(); @(negedge clk);
      chk("G_icount4", icount4, 4);
      chk("G_ccount4", ccount4, 15);
      chk("G_busy4", busy4, 0);

      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
